// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the Sysbus line arbiter.
// Pure declarations: no logic and no latency; backpressure does not apply.
package sysbus_arb_pkg;

    localparam int LINE_BITS = 512;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    // Request tag: {read, memory space, 8'h00} -> 13'h1100
    localparam logic [12:0] RD_MEM_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RECV,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the client not served last wins.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sysbus_line_arbiter.sv
// Shares the Sysbus master port between fetch (client 0) and LSU (client 1): one 64B line read per grant.
// Latency: c_req@t -> bus_reqcyc@t+1; with immediate reqack and 8 back-to-back beats, c_done@t+10.
// Backpressure: bus_reqcyc is held until bus_reqack; beats are acked only on bus_respcyc; clients wait on c_req.
module sysbus_line_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [1:0]                           c_req,
    input  logic [BUS_DATA_WIDTH-1:0]            c0_addr,
    input  logic [BUS_DATA_WIDTH-1:0]            c1_addr,
    output logic [1:0]                           c_gnt,
    output logic [1:0]                           c_done,
    output logic [LINE_BEATS*BUS_DATA_WIDTH-1:0] line_out,

    output logic                                 bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]            bus_req,
    output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
    input  logic                                 bus_reqack,
    input  logic                                 bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag,
    output logic                                 bus_respack
);

    localparam int LINE_W = LINE_BEATS * BUS_DATA_WIDTH;
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    // Byte-offset bits inside one line; cleared so the bus sees a line-aligned address.
    localparam logic [BUS_DATA_WIDTH-1:0] OFF_MASK = BUS_DATA_WIDTH'((LINE_W / 8) - 1);

    arb_state_t                state_q, state_d;
    logic [1:0]                gnt_q, gnt_d;
    logic                      last_gnt_q, last_gnt_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [LINE_W-1:0]         line_q, line_d;

    logic [1:0] arb_gnt;
    logic       resp_window;
    logic       unused_resptag;

    // Only one transaction is ever outstanding, so the response tag carries no information.
    assign unused_resptag = ^bus_resptag;

    rr_arbiter2 u_rr (
        .req      (c_req),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt)
    );

    assign resp_window = (state_q == WAIT) || (state_q == RECV);

    // Reset gating keeps an aborted transaction from acking its in-flight beat.
    assign bus_respack = resp_window && bus_respcyc && !reset;

    assign bus_reqcyc = (state_q == REQ);
    assign bus_req    = addr_q;
    assign bus_reqtag = BUS_TAG_WIDTH'(RD_MEM_TAG);
    assign c_gnt      = gnt_q;
    assign c_done     = (state_q == DONE) ? gnt_q : 2'b00;
    assign line_out   = line_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        line_d     = line_q;

        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    gnt_d      = arb_gnt;
                    last_gnt_d = arb_gnt[1];
                    addr_d     = (arb_gnt[1] ? c1_addr : c0_addr) & ~OFF_MASK;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus_reqack) begin
                    state_d = WAIT;
                end
            end
            WAIT, RECV: begin
                if (bus_respcyc) begin
                    line_d[beat_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
                    beat_d  = beat_q + 1'b1;
                    state_d = (beat_q == LAST_BEAT) ? DONE : RECV;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                beat_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            beat_q     <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
        end
    end

endmodule

// File: tb/tb_sysbus_line_arbiter.sv
// Directed bench for sysbus_line_arbiter: stimulus pushes expected bus requests and lines,
// a negedge monitor pops and compares them whenever the DUT presents them.
module tb_sysbus_line_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   c_req;
    logic [63:0]  c0_addr, c1_addr;
    logic [1:0]   c_gnt, c_done;
    logic [511:0] line_out;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_reqack;
    logic         bus_respcyc;
    logic [63:0]  bus_resp;
    logic [12:0]  bus_resptag;
    logic         bus_respack;

    always #5 clk = ~clk;

    sysbus_line_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .c_req       (c_req),
        .c0_addr     (c0_addr),
        .c1_addr     (c1_addr),
        .c_gnt       (c_gnt),
        .c_done      (c_done),
        .line_out    (line_out),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    typedef struct packed {
        logic [1:0]   who;
        logic [511:0] line;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_req_q[$];
    exp_t        mon_e;
    logic [63:0] mon_a;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int reqcyc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = seed + 64'(k) * 64'h1111;
        return l;
    endfunction

    // Monitor: compares every accepted bus request and every done pulse against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_reqcyc && bus_reqack) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", {63'd0, bus_reqcyc}, 512'd0);
                end else begin
                    mon_a = exp_req_q.pop_front();
                    check("bus_req_addr", bus_req, mon_a);
                    check("bus_reqtag", bus_reqtag, 13'h1100);
                end
            end
            if (c_done != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", c_done, 2'b00);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_client", c_done, mon_e.who);
                    check("line_out", line_out, mon_e.line);
                end
            end
        end
    end

    // Plays the bus slave for one full transaction for client `who`.
    task automatic serve(input logic [1:0] who, input logic [63:0] addr, input int ack_dly,
                         input int gap, input logic [63:0] seed, input bit drop_req);
        logic [511:0] line;
        logic [63:0]  exp_addr;
        int t;
        exp_addr = {addr[63:6], 6'b0};
        line     = mk_line(seed);
        exp_req_q.push_back(exp_addr);
        exp_q.push_back('{who, line});
        t = 0;
        while (!bus_reqcyc && t < 20) begin
            @(posedge clk); #1; t++;
        end
        reqcyc_cyc = cyc;
        check("reqcyc_seen", {63'd0, bus_reqcyc}, 512'd1);
        check("gnt_owner", c_gnt, who);
        if (drop_req) c_req = c_req & ~who;
        for (int d = 0; d < ack_dly; d++) begin
            bus_respcyc = 1'b1;
            #1;
            check("respack_in_req", {63'd0, bus_respack}, 512'd0);
            @(posedge clk); #1;
            check("reqcyc_held", {63'd0, bus_reqcyc}, 512'd1);
            check("req_addr_held", bus_req, exp_addr);
        end
        bus_respcyc = 1'b0;
        bus_reqack  = 1'b1;
        @(posedge clk); #1;
        bus_reqack = 1'b0;
        check("reqcyc_dropped", {63'd0, bus_reqcyc}, 512'd0);
        for (int k = 0; k < 8; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = line[k*64 +: 64];
            #1;
            check("respack_beat", {63'd0, bus_respack}, 512'd1);
            @(posedge clk); #1;
            bus_respcyc = 1'b0;
            bus_resp    = 64'hdead_beef_dead_beef;
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    #1;
                    check("respack_gap", {63'd0, bus_respack}, 512'd0);
                    @(posedge clk); #1;
                end
            end
        end
        c_req = c_req & ~who;
        check("done_now", c_done, who);
        check("gnt_in_done", c_gnt, who);
    endtask

    initial begin
        int t0;
        int t;
        reset = 1'b1; c_req = 2'b00; c0_addr = '0; c1_addr = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_gnt", c_gnt, 2'b00);
        check("rst_done", c_done, 2'b00);
        check("rst_line", line_out, 512'd0);
        check("rst_reqcyc", {63'd0, bus_reqcyc}, 512'd0);
        check("rst_req", bus_req, 64'd0);
        check("rst_respack", {63'd0, bus_respack}, 512'd0);
        @(posedge clk); #1;

        // 1: single request, immediate ack, back-to-back beats k*0x1111
        c0_addr = 64'h1_0047;
        c_req   = 2'b01;
        t0      = cyc;
        serve(2'b01, 64'h1_0047, 0, 0, 64'd0, 1'b0);
        check("reqcyc_latency", reqcyc_cyc - t0, 1);
        check("done_latency", cyc - t0, 10);
        @(posedge clk); #1;
        check("gnt_cleared", c_gnt, 2'b00);

        // Re-apply reset so the first tie below is the first tie after reset.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // 2: tie after reset -> 0 then 1; next tie -> 0 then 1 again
        c0_addr = 64'h2000_00c0; c1_addr = 64'h3000_017f;
        c_req = 2'b11;
        serve(2'b01, 64'h2000_00c0, 0, 0, 64'h100, 1'b0);
        serve(2'b10, 64'h3000_017f, 0, 0, 64'h200, 1'b0);
        c0_addr = 64'h4000_0001; c1_addr = 64'h5000_0002;
        c_req = 2'b11;
        serve(2'b01, 64'h4000_0001, 1, 0, 64'h300, 1'b0);
        serve(2'b10, 64'h5000_0002, 0, 0, 64'h400, 1'b0);
        @(posedge clk); #1;

        // 3: reqack delayed 5 cycles, spurious respcyc during REQ
        c1_addr = 64'hffff_ffff_ffff_ffff;
        c_req = 2'b10;
        serve(2'b10, 64'hffff_ffff_ffff_ffff, 5, 0, 64'h5555, 1'b0);
        @(posedge clk); #1;

        // 4: two idle cycles between beats; c_req dropped right after grant
        c0_addr = 64'h0000_0000_0000_0abc;
        c_req = 2'b01;
        serve(2'b01, 64'h0000_0000_0000_0abc, 0, 2, 64'h7000, 1'b1);
        @(posedge clk); #1;

        // 5: reset after beat 3 aborts the transaction
        c0_addr = 64'h8888_0010;
        c_req = 2'b01;
        exp_req_q.push_back(64'h8888_0000);
        t = 0;
        while (!bus_reqcyc && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("abort_reqcyc", {63'd0, bus_reqcyc}, 512'd1);
        bus_reqack = 1'b1;
        @(posedge clk); #1;
        bus_reqack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'(k) + 64'h9900;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        bus_resp = 64'h9904;
        #1;
        check("abort_no_ack", {63'd0, bus_respack}, 512'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_respcyc = 1'b0;
        c_req = 2'b00;
        check("abort_gnt", c_gnt, 2'b00);
        check("abort_done", c_done, 2'b00);
        check("abort_line", line_out, 512'd0);
        check("abort_reqcyc0", {63'd0, bus_reqcyc}, 512'd0);
        check("abort_req", bus_req, 64'd0);
        check("abort_respack", {63'd0, bus_respack}, 512'd0);
        c1_addr = 64'h1234_5678;
        c_req = 2'b10;
        serve(2'b10, 64'h1234_5678, 0, 0, 64'hcafe, 1'b0);
        @(posedge clk); #1;

        // 6: spurious respcyc in IDLE
        for (int i = 0; i < 3; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'hbad0 + 64'(i);
            #1;
            check("idle_respack", {63'd0, bus_respack}, 512'd0);
            @(posedge clk); #1;
            check("idle_line_kept", line_out, mk_line(64'hcafe));
            check("idle_gnt", c_gnt, 2'b00);
        end
        bus_respcyc = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("pending_done", exp_q.size(), 0);
        check("pending_req", exp_req_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
